// File: rtl/ls_ctrl_sig_sequencer.sv
// Timed write sequencer for the 4-bit ls_ctrl_sig PIO.
// A CSR-loaded step table (value + hold cycles) is replayed as single-cycle
// Avalon writes to the PIO s1 slave without CPU involvement.
module ls_ctrl_sig_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HOLD_W     = 16,
    parameter logic [3:0]  SAFE_VALUE = 4'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    input  logic        trig,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy,
    output logic        done_irq
);

    localparam int unsigned IW    = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH5 = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD, ABORT} state_t;

    state_t              state, state_nx;
    logic [3:0]          idx, idx_nx;
    logic [HOLD_W-1:0]   cnt, cnt_nx;
    logic                busy_nx, fin_nx, fin_q, advance, last;
    logic                pio_wr_nx;
    logic [3:0]          pio_val_nx;

    logic [3:0]          step_val  [DEPTH];
    logic [HOLD_W-1:0]   step_hold [DEPTH];
    logic [4:0]          nsteps;
    logic                loop_en, trig_en, done, trig_q;

    logic                csr_wr, ctrl_wr, start_ev, abort_ev, step_sel;
    logic [IW-1:0]       sidx;
    logic                unused_ok;

    assign csr_wr   = csr_chipselect & ~csr_write_n;
    assign ctrl_wr  = csr_wr && (csr_address == 5'd0);
    // ABORT in the same CTRL write suppresses START
    assign abort_ev = ctrl_wr && csr_writedata[1];
    assign start_ev = (ctrl_wr && csr_writedata[0] && !csr_writedata[1]) ||
                      (trig && !trig_q && trig_en);
    assign step_sel = csr_address[4] && ({1'b0, csr_address[3:0]} < DEPTH5);
    assign sidx     = csr_address[IW-1:0];
    assign last     = ({1'b0, idx} == (nsteps - 5'd1));
    assign pio_address = 2'b00;
    assign unused_ok   = ^csr_writedata;

    // Next-state and next-output decision for the replay FSM
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        cnt_nx     = cnt;
        busy_nx    = busy;
        fin_nx     = 1'b0;
        advance    = 1'b0;
        pio_wr_nx  = 1'b0;
        pio_val_nx = pio_writedata[3:0];
        case (state)
            IDLE: begin
                if (start_ev && !busy) begin
                    state_nx = WRITE;
                    idx_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            WRITE: begin
                // The strobe for this step is issued even if ABORT arrives now
                pio_wr_nx  = 1'b1;
                pio_val_nx = step_val[idx[IW-1:0]];
                if (abort_ev) begin
                    state_nx = ABORT;
                end else if (step_hold[idx[IW-1:0]] == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_nx   = step_hold[idx[IW-1:0]];
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (abort_ev) begin
                    state_nx = ABORT;
                end else if (cnt <= HOLD_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_nx = cnt - HOLD_W'(1);
                end
            end
            ABORT: begin
                pio_wr_nx  = 1'b1;
                pio_val_nx = SAFE_VALUE;
                state_nx   = IDLE;
                busy_nx    = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        if (advance) begin
            if (!last) begin
                idx_nx   = idx + 4'd1;
                state_nx = WRITE;
            end else if (loop_en) begin
                idx_nx   = '0;
                state_nx = WRITE;
            end else begin
                state_nx = IDLE;
                fin_nx   = 1'b1;
            end
        end
        // Completion is reported one cycle after the FSM ends so that it lines
        // up with the registered PIO outputs (final hold fully elapsed at PIO)
        if (fin_q) busy_nx = 1'b0;
    end

    // FSM, status and registered PIO master outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            fin_q          <= 1'b0;
            done_irq       <= 1'b0;
            done           <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            cnt            <= cnt_nx;
            busy           <= busy_nx;
            fin_q          <= fin_nx;
            done_irq       <= fin_q;
            pio_chipselect <= pio_wr_nx;
            pio_write_n    <= ~pio_wr_nx;
            pio_writedata  <= {28'b0, pio_val_nx};
            if (fin_q)
                done <= 1'b1;
            else if (csr_wr && csr_address == 5'd2 && csr_writedata[8])
                done <= 1'b0;
        end
    end

    // CSR configuration registers and step table
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nsteps  <= 5'd1;
            loop_en <= 1'b0;
            trig_en <= 1'b0;
            trig_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                step_val[i]  <= '0;
                step_hold[i] <= '0;
            end
        end else begin
            trig_q <= trig;
            if (ctrl_wr) begin
                loop_en <= csr_writedata[2];
                trig_en <= csr_writedata[3];
            end
            if (csr_wr && !busy) begin
                if (csr_address == 5'd1 && csr_writedata[4:0] != 5'd0)
                    nsteps <= (csr_writedata[4:0] > DEPTH5) ? DEPTH5 : csr_writedata[4:0];
                if (step_sel) begin
                    step_val[sidx]  <= csr_writedata[3:0];
                    step_hold[sidx] <= csr_writedata[16 +: HOLD_W];
                end
            end
        end
    end

    // CSR read mux, combinational from address
    always_comb begin
        csr_readdata = '0;
        if (csr_address == 5'd0) begin
            csr_readdata[3:0] = {trig_en, loop_en, done, busy};
        end else if (csr_address == 5'd1) begin
            csr_readdata[4:0] = nsteps;
        end else if (csr_address == 5'd2) begin
            csr_readdata[3:0] = idx;
            csr_readdata[8]   = done;
        end else if (step_sel) begin
            csr_readdata[3:0]         = step_val[sidx];
            csr_readdata[16 +: HOLD_W] = step_hold[sidx];
        end
    end

endmodule

// File: tb/tb_ls_ctrl_sig_sequencer.sv
// Directed bench for ls_ctrl_sig_sequencer: cycle-indexed capture of PIO
// strobes, done_irq and busy after a start edge, compared to hand timings.
module tb_ls_ctrl_sig_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        trig = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy, done_irq;

    int vectors = 0;
    int miscompares = 0;

    int          wr_n, irq_n, irq_k, busy_low_k, bad_addr;
    int          wr_k [64];
    logic [31:0] wr_v [64];
    int          inj_n = 0;
    int          inj_k [8];
    logic [4:0]  inj_a [8];
    logic [31:0] inj_d [8];

    ls_ctrl_sig_sequencer #(.DEPTH(8), .HOLD_W(16), .SAFE_VALUE(4'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_write_n(csr_write_n), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .trig(trig),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Called 1ns after an edge; the write is sampled at the next edge.
    task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write_n = 1'b0;
        @(posedge clk); #1;
        csr_chipselect = 1'b0; csr_write_n = 1'b1; csr_writedata = '0; csr_address = '0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [31:0] d);
        csr_address = a;
        @(negedge clk);
        d = csr_readdata;
        @(posedge clk); #1;
        csr_address = '0;
    endtask

    task automatic add_inj(input int k, input logic [4:0] a, input logic [31:0] d);
        inj_k[inj_n] = k; inj_a[inj_n] = a; inj_d[inj_n] = d; inj_n++;
    endtask

    // Records activity after edges N+1..N+ncyc, N being the edge just passed.
    task automatic capture(input int ncyc);
        wr_n = 0; irq_n = 0; irq_k = -1; busy_low_k = -1; bad_addr = 0;
        for (int j = 0; j < 64; j++) begin wr_k[j] = -1; wr_v[j] = 'x; end
        for (int k = 1; k <= ncyc; k++) begin
            for (int j = 0; j < inj_n; j++)
                if (inj_k[j] == k) begin
                    csr_address = inj_a[j]; csr_writedata = inj_d[j];
                    csr_chipselect = 1'b1; csr_write_n = 1'b0;
                end
            @(posedge clk); #1;
            csr_chipselect = 1'b0; csr_write_n = 1'b1; csr_writedata = '0; csr_address = '0;
            if (pio_chipselect && !pio_write_n) begin
                if (wr_n < 64) begin wr_k[wr_n] = k; wr_v[wr_n] = pio_writedata; end
                wr_n++;
                if (pio_address !== 2'b00) bad_addr++;
            end
            if (done_irq) begin if (irq_n == 0) irq_k = k; irq_n++; end
            if (!busy && busy_low_k < 0) busy_low_k = k;
        end
        inj_n = 0;
    endtask

    task automatic program_table();
        csr_write(5'd1,  32'd3);
        csr_write(5'd16, 32'h0002_0005);
        csr_write(5'd17, 32'h0000_000A);
        csr_write(5'd18, 32'h0004_0003);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        vectors++; if ({pio_chipselect, pio_write_n, pio_address} !== 4'b0100 || pio_writedata !== 32'h0) begin
            miscompares++; $display("FAIL reset_pio: cs/wn/addr=%b data=%h expected 0100 / 0", {pio_chipselect, pio_write_n, pio_address}, pio_writedata); end
        vectors++; if ({busy, done_irq} !== 2'b00) begin
            miscompares++; $display("FAIL reset_busy_irq: got %b expected 00", {busy, done_irq}); end
        csr_read(5'd0, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
        csr_read(5'd1, rd);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL reset_nsteps: got %h expected 1", rd); end
        csr_read(5'd2, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", rd); end
        csr_read(5'd16, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_step0: got %h expected 0", rd); end
    endtask

    // Runs the 5/A/3 table once; expects writes at N+1,N+4,N+5 and done at N+10.
    task automatic test_single(input string nm);
        logic [31:0] rd;
        int          ek [3] = '{1, 4, 5};
        logic [31:0] ev [3] = '{32'h5, 32'hA, 32'h3};
        capture(14);
        vectors++; if (wr_n !== 3) begin miscompares++; $display("FAIL %s_wr_count: got %0d expected 3", nm, wr_n); end
        for (int j = 0; j < 3; j++) begin
            vectors++; if (wr_k[j] !== ek[j] || wr_v[j] !== ev[j]) begin
                miscompares++; $display("FAIL %s_wr%0d: got cycle %0d data %h expected cycle %0d data %h", nm, j, wr_k[j], wr_v[j], ek[j], ev[j]); end
        end
        vectors++; if (bad_addr !== 0) begin miscompares++; $display("FAIL %s_pio_addr: %0d nonzero expected 0", nm, bad_addr); end
        vectors++; if (irq_n !== 1 || irq_k !== 10) begin
            miscompares++; $display("FAIL %s_irq: got %0d pulses first at %0d expected 1 at 10", nm, irq_n, irq_k); end
        vectors++; if (busy_low_k !== 10) begin miscompares++; $display("FAIL %s_busy_low: got %0d expected 10", nm, busy_low_k); end
        csr_read(5'd2, rd);
        vectors++; if (rd !== 32'h102) begin miscompares++; $display("FAIL %s_status: got %h expected 102", nm, rd); end
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        program_table();
        csr_write(5'd0, 32'h1);
        test_single("oneshot");
        csr_read(5'd0, rd);
        vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL oneshot_ctrl_done: got %h expected 2", rd); end
        csr_write(5'd2, 32'h100);
        csr_read(5'd0, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oneshot_done_clear: got %h expected 0", rd); end
    endtask

    task automatic test_loop_abort();
        logic [31:0] rd;
        int          ek [7] = '{1, 4, 5, 10, 13, 14, 15};
        logic [31:0] ev [7] = '{32'h5, 32'hA, 32'h3, 32'h5, 32'hA, 32'h3, 32'h0};
        csr_write(5'd0, 32'h5);
        add_inj(14, 5'd0, 32'h6);   // ABORT during the WRITE strobe of step 2
        capture(20);
        vectors++; if (wr_n !== 7) begin miscompares++; $display("FAIL loop_wr_count: got %0d expected 7", wr_n); end
        for (int j = 0; j < 7; j++) begin
            vectors++; if (wr_k[j] !== ek[j] || wr_v[j] !== ev[j]) begin
                miscompares++; $display("FAIL loop_wr%0d: got cycle %0d data %h expected cycle %0d data %h", j, wr_k[j], wr_v[j], ek[j], ev[j]); end
        end
        vectors++; if (irq_n !== 0) begin miscompares++; $display("FAIL loop_irq: got %0d expected 0", irq_n); end
        vectors++; if (busy_low_k !== 15) begin miscompares++; $display("FAIL loop_busy_low: got %0d expected 15", busy_low_k); end
        csr_read(5'd2, rd);
        vectors++; if (rd !== 32'h002) begin miscompares++; $display("FAIL abort_status: got %h expected 002", rd); end
        csr_read(5'd0, rd);
        vectors++; if (rd !== 32'h4) begin miscompares++; $display("FAIL abort_ctrl: got %h expected 4", rd); end
    endtask

    task automatic test_loop_clear();
        csr_write(5'd0, 32'h5);
        add_inj(6, 5'd0, 32'h0);    // clear LOOP during the first pass
        test_single("loopclr");
        csr_write(5'd2, 32'h100);
    endtask

    task automatic test_trig();
        csr_write(5'd0, 32'h8);
        trig = 1'b1;
        capture(20);
        trig = 1'b0;
        vectors++; if (wr_n !== 3 || wr_k[0] !== 2 || wr_v[0] !== 32'h5) begin
            miscompares++; $display("FAIL trig_seq: got %0d writes first at %0d data %h expected 3 at 2 data 5", wr_n, wr_k[0], wr_v[0]); end
        vectors++; if (irq_n !== 1 || irq_k !== 11) begin
            miscompares++; $display("FAIL trig_irq: got %0d pulses at %0d expected 1 at 11", irq_n, irq_k); end
        capture(10);
        vectors++; if (wr_n !== 0) begin miscompares++; $display("FAIL trig_fall: got %0d writes expected 0", wr_n); end
        csr_write(5'd2, 32'h100);
        csr_write(5'd0, 32'h0);
        trig = 1'b1;
        capture(15);
        trig = 1'b0;
        vectors++; if (wr_n !== 0 || busy_low_k !== 1) begin
            miscompares++; $display("FAIL trig_disabled: got %0d writes busy_low %0d expected 0 / 1", wr_n, busy_low_k); end
    endtask

    task automatic test_busy_writes();
        logic [31:0] rd;
        csr_write(5'd0, 32'h1);
        add_inj(2, 5'd17, 32'h0000_000F);
        add_inj(3, 5'd1,  32'd1);
        add_inj(6, 5'd0,  32'h1);
        test_single("busywr");
        csr_read(5'd17, rd);
        vectors++; if (rd !== 32'h0000_000A) begin miscompares++; $display("FAIL busywr_step1: got %h expected 0000000a", rd); end
        csr_read(5'd1, rd);
        vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL busywr_nsteps: got %h expected 3", rd); end
        csr_write(5'd2, 32'h100);
    endtask

    task automatic test_csr_boundaries();
        logic [31:0] rd;
        csr_write(5'd1, 32'd1);
        csr_write(5'd1, 32'd0);
        csr_read(5'd1, rd);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL nsteps_zero: got %h expected 1", rd); end
        csr_write(5'd1, 32'd31);
        csr_read(5'd1, rd);
        vectors++; if (rd !== 32'd8) begin miscompares++; $display("FAIL nsteps_sat: got %h expected 8", rd); end
        csr_write(5'd5, 32'hFFFF_FFFF);
        csr_read(5'd5, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL unmapped: got %h expected 0", rd); end
        csr_write(5'd24, 32'hFFFF_FFFF);
        csr_read(5'd24, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL step_oob: got %h expected 0", rd); end
        csr_write(5'd1, 32'd3);
        csr_write(5'd0, 32'h3);
        capture(12);
        vectors++; if (wr_n !== 0 || busy_low_k !== 1) begin
            miscompares++; $display("FAIL abort_start_idle: got %0d writes busy_low %0d expected 0 / 1", wr_n, busy_low_k); end
        csr_read(5'd2, rd);
        vectors++; if (rd !== 32'h002) begin miscompares++; $display("FAIL idle_abort_status: got %h expected 002", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        csr_write(5'd0, 32'h1);
        capture(2);
        vectors++; if (busy !== 1'b1 || pio_writedata !== 32'h5) begin
            miscompares++; $display("FAIL pre_reset: busy %b data %h expected 1 / 5", busy, pio_writedata); end
        reset_n = 1'b0;
        #1;
        vectors++; if ({pio_chipselect, pio_write_n, busy, done_irq} !== 4'b0100 || pio_writedata !== 32'h0) begin
            miscompares++; $display("FAIL async_reset: cs/wn/busy/irq=%b data=%h expected 0100 / 0", {pio_chipselect, pio_write_n, busy, done_irq}, pio_writedata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        capture(4);
        vectors++; if (wr_n !== 0) begin miscompares++; $display("FAIL reset_no_safe: got %0d writes expected 0", wr_n); end
        csr_read(5'd1, rd);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL post_reset_nsteps: got %h expected 1", rd); end
        csr_read(5'd18, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL post_reset_step2: got %h expected 0", rd); end
        test_one_shot();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_one_shot();
        test_loop_abort();
        test_loop_clear();
        test_trig();
        test_busy_writes();
        test_csr_boundaries();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
